cont_config_core: RTL

CONT_CONFIG_CORE -- requirements
Module: cont_config_core

---
 rtl/cont_config_core.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cont_config_core.sv
// Timer/counter core behind an AXI4-Lite register file: prescaled up/down
// counting, one-shot mode, registered compare output and sticky wrap interrupt.
module cont_config_core #(
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] period_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] compare_reg,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] presc_reg,
  input  logic                          ctrl_wr,
  input  logic                          irq_ack,
  output logic [C_S_AXI_DATA_WIDTH-1:0] count_out,
  output logic                          tick,
  output logic                          cmp_out,
  output logic                          irq,
  output logic [C_S_AXI_DATA_WIDTH-1:0] status_out
);

  localparam int W = C_S_AXI_DATA_WIDTH;

  // status_out[1:0] is the full state view: 00 IDLE, 01 RUN, 10 DONE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [15:0]   presc_cnt;
  logic          wrap;

  logic          en;
  logic          dir;
  logic          oneshot;
  logic          irq_en;
  logic [15:0]   presc_val;
  logic [W-1:0]  reload;
  logic          presc_hit;
  logic          step;
  logic          at_term;
  logic          term;
  logic [W-1:0]  count_step;
  logic          wrap_next;
  logic          unused_bits;

  assign en        = ctrl_reg[0];
  assign dir       = ctrl_reg[1];
  assign oneshot   = ctrl_reg[2];
  assign irq_en    = ctrl_reg[3];
  assign presc_val = presc_reg[15:0];
  assign reload    = dir ? period_reg : '0;

  assign unused_bits = ^{ctrl_reg[W-1:4], presc_reg[W-1:16]};

  // A step only happens while actually running; a control write pre-empts it.
  assign presc_hit = (presc_cnt == presc_val);
  assign step      = (state == ST_RUN) && en && !ctrl_wr && presc_hit;
  assign at_term   = dir ? (count_out == '0) : (count_out == period_reg);
  assign term      = step && at_term;

  always_comb begin
    count_step = count_out;
    if (dir) begin
      count_step = at_term ? period_reg : (count_out - W'(1));
    end else begin
      count_step = at_term ? '0 : (count_out + W'(1));
    end
  end

  // Set wins over acknowledge so a coincident terminal event is never lost.
  always_comb begin
    wrap_next = wrap;
    if (term) begin
      wrap_next = 1'b1;
    end else if (irq_ack) begin
      wrap_next = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= ST_IDLE;
      count_out <= '0;
      presc_cnt <= '0;
      tick      <= 1'b0;
      cmp_out   <= 1'b0;
      wrap      <= 1'b0;
      irq       <= 1'b0;
    end else begin
      cmp_out <= (count_out < compare_reg);
      tick    <= term;
      wrap    <= wrap_next;
      irq     <= wrap_next & irq_en;

      if (ctrl_wr) begin
        count_out <= reload;
        presc_cnt <= '0;
        state     <= en ? ST_RUN : ST_IDLE;
      end else if (!en) begin
        count_out <= reload;
        presc_cnt <= '0;
        state     <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            count_out <= reload;
            presc_cnt <= '0;
            state     <= ST_RUN;
          end
          ST_RUN: begin
            if (presc_hit) begin
              presc_cnt <= '0;
              // One-shot freezes on the terminal value instead of reloading.
              if (term && oneshot) begin
                state <= ST_DONE;
              end else begin
                count_out <= count_step;
              end
            end else begin
              presc_cnt <= presc_cnt + 16'd1;
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    status_out    = '0;
    status_out[0] = (state == ST_RUN);
    status_out[1] = (state == ST_DONE);
    status_out[2] = wrap;
  end

endmodule
